// File: rtl/spi_lcd_fill_if.sv
// Byte stream from the fill engine into the SPI LCD module's input FIFO.
//   dc   : D/C flag of the presented byte (0 = command, 1 = data)
//   data : presented byte
//   put  : write strobe; a byte is taken in every cycle put is high
//   full : FIFO full, combinational from the FIFO
interface spi_lcd_fill_if;
    logic       dc;
    logic [7:0] data;
    logic       put;
    logic       full;

    modport master (output dc, output data, output put, input full);
    modport slave  (input dc, input data, input put, output full);
endinterface

// File: rtl/spi_lcd_fill.sv
// Rectangle fill engine: on start, streams a MIPI-DCS CASET/RASET window,
// RAMWR, then width*height RGB565 pixels (MSB first) into the LCD FIFO.
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   start   : fill request, sampled only in IDLE
//   x0,x1   : first/last column (inclusive), latched on accepted start
//   y0,y1   : first/last row (inclusive), latched on accepted start
//   color   : RGB565 fill colour, latched on accepted start
//   busy    : fill in progress
//   done    : one-cycle pulse at the end of a fill (also for a rejected window)
//   lcd     : dc/data/put/full byte stream to the downstream FIFO
module spi_lcd_fill #(
    parameter int XW = 9
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [XW-1:0]        x0,
    input  logic [XW-1:0]        x1,
    input  logic [XW-1:0]        y0,
    input  logic [XW-1:0]        y1,
    input  logic [15:0]          color,
    output logic                 busy,
    output logic                 done,
    spi_lcd_fill_if.master       lcd
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_PHI  = 3'd2;
    localparam logic [2:0] S_PLO  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic [3:0] HDR_LAST = 4'd10;

    logic [2:0]    state;
    logic          busy_q;
    logic [3:0]    hidx;
    logic [XW-1:0] col;
    logic [XW-1:0] row;

    logic [XW-1:0] x0_q, x1_q, y0_q, y1_q;
    logic [15:0]   color_q;

    logic [XW-1:0] w_m1;
    logic [XW-1:0] h_m1;
    logic          emitting;
    logic          put_w;
    logic          dc_w;
    logic [7:0]    data_w;

    // Coordinates go out as 16-bit big-endian words.
    function automatic logic [15:0] ext16(input logic [XW-1:0] v);
        logic [15:0] r;
        r = '0;
        r[XW-1:0] = v;
        return r;
    endfunction

    // Header byte at index idx as {dc, data}.
    function automatic logic [8:0] hdr_byte(
        input logic [3:0]  idx,
        input logic [15:0] xa,
        input logic [15:0] xb,
        input logic [15:0] ya,
        input logic [15:0] yb
    );
        logic [8:0] b;
        case (idx)
            4'd0:    b = {1'b0, 8'h2A};
            4'd1:    b = {1'b1, xa[15:8]};
            4'd2:    b = {1'b1, xa[7:0]};
            4'd3:    b = {1'b1, xb[15:8]};
            4'd4:    b = {1'b1, xb[7:0]};
            4'd5:    b = {1'b0, 8'h2B};
            4'd6:    b = {1'b1, ya[15:8]};
            4'd7:    b = {1'b1, ya[7:0]};
            4'd8:    b = {1'b1, yb[15:8]};
            4'd9:    b = {1'b1, yb[7:0]};
            default: b = {1'b0, 8'h2C};
        endcase
        return b;
    endfunction

    // Differences are safe: the window is only accepted when x1>=x0, y1>=y0.
    assign w_m1 = x1_q - x0_q;
    assign h_m1 = y1_q - y0_q;

    assign emitting = (state == S_HDR) || (state == S_PHI) || (state == S_PLO);
    assign put_w    = emitting & ~lcd.full;

    // Presented byte depends only on registered state, so it holds while full stalls.
    always_comb begin
        dc_w   = 1'b0;
        data_w = 8'h00;
        case (state)
            S_HDR: {dc_w, data_w} = hdr_byte(hidx, ext16(x0_q), ext16(x1_q),
                                             ext16(y0_q), ext16(y1_q));
            S_PHI: {dc_w, data_w} = {1'b1, color_q[15:8]};
            S_PLO: {dc_w, data_w} = {1'b1, color_q[7:0]};
            default: ;
        endcase
    end

    assign lcd.put  = put_w;
    assign lcd.dc   = dc_w;
    assign lcd.data = data_w;
    assign busy     = busy_q;
    assign done     = (state == S_FIN);

    // Window and colour are pure data; only the control path is reset.
    always_ff @(posedge clock) begin
        if (state == S_IDLE && start) begin
            x0_q    <= x0;
            x1_q    <= x1;
            y0_q    <= y0;
            y1_q    <= y1;
            color_q <= color;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            hidx   <= '0;
            col    <= '0;
            row    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        hidx   <= '0;
                        col    <= '0;
                        row    <= '0;
                        if (x1 < x0 || y1 < y0)
                            state <= S_FIN;
                        else
                            state <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (put_w) begin
                        if (hidx == HDR_LAST) begin
                            state <= S_PHI;
                            col   <= '0;
                            row   <= '0;
                        end else begin
                            hidx <= hidx + 4'd1;
                        end
                    end
                end
                S_PHI: begin
                    if (put_w)
                        state <= S_PLO;
                end
                S_PLO: begin
                    if (put_w) begin
                        if (col == w_m1) begin
                            col <= '0;
                            if (row == h_m1) begin
                                // busy drops together with the done cycle.
                                state  <= S_FIN;
                                busy_q <= 1'b0;
                            end else begin
                                row   <= row + 1'b1;
                                state <= S_PHI;
                            end
                        end else begin
                            col   <= col + 1'b1;
                            state <= S_PHI;
                        end
                    end
                end
                S_FIN: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_lcd_fill.sv
// Self-checking bench for spi_lcd_fill: directed and random fills compared
// against a queue-based byte-stream model, plus timing, stall and reset cases.
module tb_spi_lcd_fill;

    localparam int XW = 9;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic [XW-1:0] x0, x1, y0, y1;
    logic [15:0]   color;
    logic          busy, done;
    logic          full_drv;

    spi_lcd_fill_if lcd ();
    assign lcd.full = full_drv;

    spi_lcd_fill #(.XW(XW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .x0      (x0),
        .x1      (x1),
        .y0      (y0),
        .y1      (y1),
        .color   (color),
        .busy    (busy),
        .done    (done),
        .lcd     (lcd)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected {dc,data} stream for a window, from the byte-format rules.
    task automatic model(input int ax0, input int ax1, input int ay0, input int ay1, input int col);
        int npix;
        exp_q.delete();
        if (ax1 < ax0 || ay1 < ay0) return;
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, 8'(ax0 >> 8)});
        exp_q.push_back({1'b1, 8'(ax0)});
        exp_q.push_back({1'b1, 8'(ax1 >> 8)});
        exp_q.push_back({1'b1, 8'(ax1)});
        exp_q.push_back({1'b0, 8'h2B});
        exp_q.push_back({1'b1, 8'(ay0 >> 8)});
        exp_q.push_back({1'b1, 8'(ay0)});
        exp_q.push_back({1'b1, 8'(ay1 >> 8)});
        exp_q.push_back({1'b1, 8'(ay1)});
        exp_q.push_back({1'b0, 8'h2C});
        npix = (ax1 - ax0 + 1) * (ay1 - ay0 + 1);
        for (int i = 0; i < npix; i++) begin
            exp_q.push_back({1'b1, 8'(col >> 8)});
            exp_q.push_back({1'b1, 8'(col)});
        end
    endtask

    task automatic run_fill(input int ax0, input int ax1, input int ay0, input int ay1,
                            input int col, input int full_pct, input bit disturb,
                            input string nm);
        int cyc, last_put, done_cyc, viol, nmin;
        model(ax0, ax1, ay0, ay1, col);
        got_q.delete();
        viol = 0;
        @(posedge clock); #1;
        x0 = ax0[XW-1:0]; x1 = ax1[XW-1:0];
        y0 = ay0[XW-1:0]; y1 = ay1[XW-1:0];
        color = col[15:0];
        full_drv = 1'b0;
        start = 1'b1;
        @(posedge clock); #1;               // edge t samples start
        start = 1'b0;
        full_drv = ($urandom_range(0, 99) < full_pct);
        cyc = 0; last_put = -1; done_cyc = -1;
        while (cyc < 5000) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) chk({nm, "/busy_t1"}, busy, 1);
            if (lcd.put) begin
                got_q.push_back({lcd.dc, lcd.data});
                last_put = cyc;
                if (full_drv) viol++;
            end
            if (done) begin
                done_cyc = cyc;
                chk({nm, "/busy_at_done"}, busy, (exp_q.size() == 0) ? 1 : 0);
                break;
            end
            @(posedge clock); #1;
            full_drv = ($urandom_range(0, 99) < full_pct);
            if (disturb) begin
                x0 = XW'($urandom); x1 = XW'($urandom);
                y0 = XW'($urandom); y1 = XW'($urandom);
                color = 16'($urandom);
                start = (cyc >= 2 && cyc <= 4);
            end
        end
        start = 1'b0;
        if (done_cyc < 0) chk({nm, "/done_timeout"}, 0, 1);
        chk({nm, "/put_while_full"}, viol, 0);
        chk({nm, "/nbytes"}, got_q.size(), exp_q.size());
        nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++)
            chk($sformatf("%s/byte%0d", nm, i), got_q[i], exp_q[i]);
        if (exp_q.size() == 0)
            chk({nm, "/done_cycle"}, done_cyc, 1);
        else
            chk({nm, "/done_after_last"}, done_cyc, last_put + 1);
        if (full_pct == 0 && exp_q.size() != 0)
            chk({nm, "/last_put_cycle"}, last_put, exp_q.size());
        @(posedge clock); #1;
        full_drv = 1'b0;
        @(negedge clock);
        chk({nm, "/idle_busy"}, busy, 0);
        chk({nm, "/idle_done"}, done, 0);
        chk({nm, "/idle_put"}, lcd.put, 0);
    endtask

    initial begin
        int puts_after;
        int rx0, rw, ry0, rh;
        reset_n = 1'b1; start = 1'b0; full_drv = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst/busy", busy, 0);
        chk("rst/done", done, 0);
        chk("rst/put", lcd.put, 0);
        chk("rst/dc", lcd.dc, 0);
        chk("rst/data", lcd.data, 0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        run_fill(3, 3, 5, 5, 'hF800, 0, 0, "px1x1");
        run_fill(0, 2, 1, 2, 'h07E0, 0, 0, "px3x2");
        run_fill(3, 3, 5, 5, 'hF800, 50, 0, "px1x1_full");
        run_fill(4, 2, 0, 0, 'h1234, 0, 0, "rej_x");
        run_fill(0, 0, 7, 6, 'h1234, 0, 0, "rej_y");
        run_fill(1, 3, 2, 3, 'hABCD, 0, 1, "start_busy");
        run_fill(0, 511, 511, 511, 'h5A3C, 0, 0, "full_row");

        // Reset during pixel bytes.
        @(posedge clock); #1;
        x0 = 0; x1 = 7; y0 = 0; y1 = 3; color = 16'h00FF; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (20) @(posedge clock);
        @(negedge clock);
        chk("mid_rst/pre_put", lcd.put, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst/put", lcd.put, 0);
        chk("mid_rst/busy", busy, 0);
        chk("mid_rst/done", done, 0);
        @(posedge clock); #1 reset_n = 1'b1;
        puts_after = 0;
        repeat (6) begin
            @(negedge clock);
            if (lcd.put || busy || done) puts_after++;
        end
        chk("mid_rst/quiet", puts_after, 0);
        run_fill(2, 3, 4, 4, 'hC0DE, 0, 0, "after_rst");

        for (int k = 0; k < 8; k++) begin
            rx0 = $urandom_range(0, 505);
            rw  = $urandom_range(0, 3);
            ry0 = $urandom_range(0, 505);
            rh  = $urandom_range(0, 3);
            run_fill(rx0, rx0 + rw, ry0, ry0 + rh, int'($urandom_range(0, 65535)),
                     (k % 3) * 35, k[0], $sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
